// File: rtl/icache_pkg.sv
// Shared types for the direct-mapped instruction cache: address overlay, frame
// layout and FSM state encoding.
package icache_pkg;

   typedef logic [31:0] word_t;

   localparam int WORD_W = 32;
   localparam int IIDX_W = 4;
   localparam int IBYT_W = 2;
   localparam int ITAG_W = WORD_W - IIDX_W - IBYT_W;

   typedef struct packed {
      logic [ITAG_W-1:0] tag;
      logic [IIDX_W-1:0] idx;
      logic [IBYT_W-1:0] bytoff;
   } icachef_t;

   typedef struct packed {
      logic              valid;
      logic [ITAG_W-1:0] tag;
      word_t             data;
   } icache_frame_t;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-port bundle (datapath <-> icache) and memory-read bundle
// (icache <-> memory controller).
interface icache_dp_if;
   import icache_pkg::*;

   logic  imemREN;
   word_t imemaddr;
   logic  ihit;
   word_t imemload;

   modport master (output imemREN, imemaddr, input  ihit, imemload);
   modport slave  (input  imemREN, imemaddr, output ihit, imemload);
endinterface

interface icache_mem_if;
   import icache_pkg::*;

   logic  iREN;
   word_t iaddr;
   logic  iwait;
   word_t iload;

   modport master (output iREN, iaddr, input  iwait, iload);
   modport slave  (input  iREN, iaddr, output iwait, iload);
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with zero-cycle hits and a
// two-state miss FSM. Optional hit/miss counters under ICACHE_STATS_EN.
module icache
   import icache_pkg::*;
#(
   parameter int SETS    = 16,
   parameter int IDX_W   = 4,
   parameter int PC_BITS = 32
) (
   input  logic          CLK,
   input  logic          nRST,
   icache_dp_if.slave    dp_if,
   icache_mem_if.master  mem_if
`ifdef ICACHE_STATS_EN
   ,
   output word_t         hit_count,
   output word_t         miss_count
`endif
);

   icache_frame_t               r_frame [SETS];
   icache_state_t               r_state;
   icachef_t                    r_fill_addr;
   logic                        r_iren;

   logic [IDX_W-1:0]            w_idx;
   logic [PC_BITS-IDX_W-3:0]    w_tag;
   logic                        w_hit;
   logic                        w_miss;
   logic                        w_unused_bytoff;

   assign w_idx           = dp_if.imemaddr[IDX_W+1:2];
   assign w_tag           = dp_if.imemaddr[PC_BITS-1:IDX_W+2];
   assign w_unused_bytoff = ^dp_if.imemaddr[1:0];

   // Lookup is only honoured in IDLE so a stale array read never shows up mid-fill.
   assign w_hit  = (r_state == IDLE) && dp_if.imemREN &&
                   r_frame[w_idx].valid && (r_frame[w_idx].tag == w_tag);
   assign w_miss = (r_state == IDLE) && dp_if.imemREN && !w_hit;

   assign dp_if.ihit     = w_hit;
   assign dp_if.imemload = w_hit ? r_frame[w_idx].data : '0;
   assign mem_if.iREN    = r_iren;
   assign mem_if.iaddr   = r_iren ? word_t'(r_fill_addr) : '0;

   // Only valid bits are reset; tag/data hold whatever they had until refilled.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state     <= IDLE;
         r_iren      <= 1'b0;
         r_fill_addr <= '0;
         for (int i = 0; i < SETS; i++) begin
            r_frame[i].valid <= 1'b0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (w_miss) begin
                  r_state     <= FETCH;
                  r_iren      <= 1'b1;
                  r_fill_addr <= icachef_t'({dp_if.imemaddr[PC_BITS-1:2], 2'b00});
               end
            end
            FETCH: begin
               if (!mem_if.iwait) begin
                  r_state                     <= IDLE;
                  r_iren                      <= 1'b0;
                  r_frame[r_fill_addr.idx] <= '{valid: 1'b1,
                                                tag:   r_fill_addr.tag,
                                                data:  mem_if.iload};
               end
            end
            default: begin
               r_state <= IDLE;
               r_iren  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ICACHE_STATS_EN
   word_t r_hit_count;
   word_t r_miss_count;

   // Counters wrap naturally; stalled repeat hits are each counted.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         if (w_hit)  r_hit_count  <= r_hit_count + 32'd1;
         if (w_miss) r_miss_count <= r_miss_count + 32'd1;
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif

endmodule
